// File: rtl/nk_board_game_fsm.sv
// N x N K-in-a-row game controller: click edge detect, move placement,
// win/draw detection, saturating scores and optional first-player alternation.
module nk_board_game_fsm #(
    parameter int N         = 3,
    parameter int K         = 3,
    parameter int SCORE_W   = 4,
    parameter int ALT_FIRST = 0
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [N*N-1:0]     cuadro,
    input  logic               erase,
    input  logic               restart,
    input  logic               randomClick,
    output logic [N*N-1:0]     x,
    output logic [N*N-1:0]     o,
    output logic               turnoX,
    output logic [5:0]         move_count,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic               inc_x_score,
    output logic               inc_o_score,
    output logic               resetScore,
    output logic               invalid_move,
    output logic               displayStartPlaying,
    output logic               displayGanadorX,
    output logic               displayGanadorO,
    output logic               displayEmpate,
    output logic [3:0]         state
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WAIT  = 4'd1,
        S_PLACE = 4'd2,
        S_CHECK = 4'd3,
        S_OVER  = 4'd4
    } state_t;

    typedef enum logic [1:0] {
        W_DRAW = 2'd0,
        W_X    = 2'd1,
        W_O    = 2'd2
    } win_t;

    state_t             r_state;
    win_t               r_winner;
    logic [NN-1:0]      r_x;
    logic [NN-1:0]      r_o;
    logic [NN-1:0]      r_prev;
    logic [IW-1:0]      r_sel;
    logic               r_turn;
    logic               r_first;
    logic [5:0]         r_cnt;
    logic [SCORE_W-1:0] r_sx;
    logic [SCORE_W-1:0] r_so;
    logic               r_incx;
    logic               r_inco;
    logic               r_rsts;
    logic               r_inv;

    logic               w_click;
    logic [IW-1:0]      w_idx;
    logic               w_occ;
    logic [NN-1:0]      w_board;
    logic               w_win;

    function automatic logic [NN-1:0] line_mask(int r0, int c0, int dr, int dc);
        logic [NN-1:0] m;
        m = '0;
        for (int k = 0; k < K; k++)
            m[(r0 + k * dr) * N + c0 + k * dc] = 1'b1;
        return m;
    endfunction

    function automatic logic hit(logic [NN-1:0] b, logic [NN-1:0] m);
        return (b & m) == m;
    endfunction

    assign w_click = (|cuadro) && !(|r_prev);
    assign w_occ   = r_x[w_idx] | r_o[w_idx];
    assign w_board = r_turn ? r_x : r_o;

    // Descending scan leaves the lowest set index in w_idx
    always_comb begin
        w_idx = '0;
        for (int i = NN - 1; i >= 0; i--)
            if (cuadro[i]) w_idx = IW'(i);
    end

    always_comb begin
        w_win = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (c + K <= N)
                    w_win = w_win | hit(w_board, line_mask(r, c, 0, 1));
                if (r + K <= N)
                    w_win = w_win | hit(w_board, line_mask(r, c, 1, 0));
                if (r + K <= N && c + K <= N)
                    w_win = w_win | hit(w_board, line_mask(r, c, 1, 1));
                if (r + K <= N && c >= K - 1)
                    w_win = w_win | hit(w_board, line_mask(r, c, 1, -1));
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_winner <= W_DRAW;
            r_x      <= '0;
            r_o      <= '0;
            r_prev   <= '0;
            r_sel    <= '0;
            r_turn   <= 1'b1;
            r_first  <= 1'b1;
            r_cnt    <= '0;
            r_sx     <= '0;
            r_so     <= '0;
            r_incx   <= 1'b0;
            r_inco   <= 1'b0;
            r_rsts   <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            r_prev <= cuadro;
            r_incx <= 1'b0;
            r_inco <= 1'b0;
            r_rsts <= 1'b0;
            r_inv  <= 1'b0;
            if (restart) begin
                r_state <= S_IDLE;
                r_x     <= '0;
                r_o     <= '0;
                r_cnt   <= '0;
                r_sx    <= '0;
                r_so    <= '0;
                r_rsts  <= 1'b1;
                r_turn  <= 1'b1;
                r_first <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_click) begin
                            r_sel   <= w_idx;
                            r_state <= S_PLACE;
                        end
                    end
                    S_WAIT: begin
                        if (w_click) begin
                            if (w_occ) begin
                                r_inv <= 1'b1;
                            end else begin
                                r_sel   <= w_idx;
                                r_state <= S_PLACE;
                            end
                        end
                    end
                    S_PLACE: begin
                        if (r_turn) r_x[r_sel] <= 1'b1;
                        else        r_o[r_sel] <= 1'b1;
                        r_cnt   <= r_cnt + 6'd1;
                        r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_win) begin
                            if (r_turn) begin
                                r_incx   <= 1'b1;
                                r_winner <= W_X;
                                if (!(&r_sx)) r_sx <= r_sx + 1'b1;
                            end else begin
                                r_inco   <= 1'b1;
                                r_winner <= W_O;
                                if (!(&r_so)) r_so <= r_so + 1'b1;
                            end
                            r_state <= S_OVER;
                        end else if (r_cnt == 6'(NN)) begin
                            r_winner <= W_DRAW;
                            r_state  <= S_OVER;
                        end else begin
                            r_turn  <= ~r_turn;
                            r_state <= S_WAIT;
                        end
                    end
                    S_OVER: begin
                        if (randomClick) begin
                            r_x     <= '0;
                            r_o     <= '0;
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                            // Loser starts next; after a draw the non-starter does
                            if (ALT_FIRST != 0) begin
                                case (r_winner)
                                    W_X: begin
                                        r_turn  <= 1'b0;
                                        r_first <= 1'b0;
                                    end
                                    W_O: begin
                                        r_turn  <= 1'b1;
                                        r_first <= 1'b1;
                                    end
                                    default: begin
                                        r_turn  <= ~r_first;
                                        r_first <= ~r_first;
                                    end
                                endcase
                            end else begin
                                r_turn  <= 1'b1;
                                r_first <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
                if (erase) begin
                    r_sx   <= '0;
                    r_so   <= '0;
                    r_rsts <= 1'b1;
                end
            end
        end
    end

    assign x                   = r_x;
    assign o                   = r_o;
    assign turnoX              = r_turn;
    assign move_count          = r_cnt;
    assign score_x             = r_sx;
    assign score_o             = r_so;
    assign inc_x_score         = r_incx;
    assign inc_o_score         = r_inco;
    assign resetScore          = r_rsts;
    assign invalid_move        = r_inv;
    assign state               = r_state;
    assign displayStartPlaying = (r_state == S_IDLE);
    assign displayGanadorX     = (r_state == S_OVER) && (r_winner == W_X);
    assign displayGanadorO     = (r_state == S_OVER) && (r_winner == W_O);
    assign displayEmpate       = (r_state == S_OVER) && (r_winner == W_DRAW);

endmodule

// File: tb/tb_nk_board_game_fsm.sv
// Bench for nk_board_game_fsm: 3x3 default instance plus a 5x5/K=4
// instance with 2-bit scores and loser-starts alternation.
module tb_nk_board_game_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  c0, x0, o0;
    logic        er0, rs0, rc0, t0, ix0, io0, rsc0, inv0;
    logic        dsp0, dgx0, dgo0, de0;
    logic [5:0]  mc0;
    logic [3:0]  sx0, so0, st0;

    logic [24:0] c1, x1, o1;
    logic        er1, rs1, rc1, t1, ix1, io1, rsc1, inv1;
    logic        dsp1, dgx1, dgo1, de1;
    logic [5:0]  mc1;
    logic [1:0]  sx1, so1;
    logic [3:0]  st1;

    nk_board_game_fsm u0 (
        .clk_100MHz(clk), .reset(rst), .cuadro(c0), .erase(er0),
        .restart(rs0), .randomClick(rc0), .x(x0), .o(o0), .turnoX(t0),
        .move_count(mc0), .score_x(sx0), .score_o(so0),
        .inc_x_score(ix0), .inc_o_score(io0), .resetScore(rsc0),
        .invalid_move(inv0), .displayStartPlaying(dsp0),
        .displayGanadorX(dgx0), .displayGanadorO(dgo0),
        .displayEmpate(de0), .state(st0)
    );

    nk_board_game_fsm #(.N(5), .K(4), .SCORE_W(2), .ALT_FIRST(1)) u1 (
        .clk_100MHz(clk), .reset(rst), .cuadro(c1), .erase(er1),
        .restart(rs1), .randomClick(rc1), .x(x1), .o(o1), .turnoX(t1),
        .move_count(mc1), .score_x(sx1), .score_o(so1),
        .inc_x_score(ix1), .inc_o_score(io1), .resetScore(rsc1),
        .invalid_move(inv1), .displayStartPlaying(dsp1),
        .displayGanadorX(dgx1), .displayGanadorO(dgo1),
        .displayEmpate(de1), .state(st1)
    );

    typedef struct {
        int         d;
        bit         isx;
        int         cyc;
    } ev_t;
    ev_t q[$];

    typedef struct {
        int         sq;
        int         win;
        logic [8:0] ex;
        logic [8:0] eo;
        logic [3:0] st;
        logic       tn;
        logic [5:0] mc;
    } vec_t;
    vec_t dg[5];
    vec_t dr[9];
    int   rw[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input int d, input bit isx);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL pulse_unexpected: got dut%0d isx=%0d cyc=%0d want none",
                     d, isx, cyc);
        end else begin
            e = q.pop_front();
            if (e.d != d || e.isx != isx || e.cyc != cyc) begin
                failures++;
                $display("FAIL pulse: got dut%0d isx=%0d cyc=%0d want dut%0d isx=%0d cyc=%0d",
                         d, isx, cyc, e.d, e.isx, e.cyc);
            end
        end
    endtask

    // Pulse one square; returns after the CHECK result is visible
    task automatic click(input int d, input int sq, input int win, input bit erck);
        @(negedge clk);
        if (win != 0) q.push_back('{d, win == 1, cyc + 3});
        if (d == 0) c0 = 9'(1) << sq;
        else        c1 = 25'(1) << sq;
        @(negedge clk);
        c0 = '0;
        c1 = '0;
        @(negedge clk);
        if (erck) er0 = 1'b1;
        @(negedge clk);
        er0 = 1'b0;
    endtask

    task automatic rclick(input int d);
        @(negedge clk);
        if (d == 0) rc0 = 1'b1;
        else        rc1 = 1'b1;
        @(negedge clk);
        rc0 = 1'b0;
        rc1 = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        click(0, v.sq, v.win, 1'b0);
        chk({tag, "_x"},  x0,  v.ex);
        chk({tag, "_o"},  o0,  v.eo);
        chk({tag, "_st"}, st0, v.st);
        chk({tag, "_tn"}, t0,  v.tn);
        chk({tag, "_mc"}, mc0, v.mc);
    endtask

    initial begin
        rst = 1'b1;
        c0 = '0; er0 = 0; rs0 = 0; rc0 = 0;
        c1 = '0; er1 = 0; rs1 = 0; rc1 = 0;

        dg[0] = '{0, 0, 9'h001, 9'h000, 4'd1, 1'b0, 6'd1};
        dg[1] = '{1, 0, 9'h001, 9'h002, 4'd1, 1'b1, 6'd2};
        dg[2] = '{4, 0, 9'h011, 9'h002, 4'd1, 1'b0, 6'd3};
        dg[3] = '{2, 0, 9'h011, 9'h006, 4'd1, 1'b1, 6'd4};
        dg[4] = '{8, 1, 9'h111, 9'h006, 4'd4, 1'b1, 6'd5};

        dr[0] = '{0, 0, 9'h001, 9'h000, 4'd1, 1'b0, 6'd1};
        dr[1] = '{1, 0, 9'h001, 9'h002, 4'd1, 1'b1, 6'd2};
        dr[2] = '{2, 0, 9'h005, 9'h002, 4'd1, 1'b0, 6'd3};
        dr[3] = '{4, 0, 9'h005, 9'h012, 4'd1, 1'b1, 6'd4};
        dr[4] = '{3, 0, 9'h00D, 9'h012, 4'd1, 1'b0, 6'd5};
        dr[5] = '{5, 0, 9'h00D, 9'h032, 4'd1, 1'b1, 6'd6};
        dr[6] = '{7, 0, 9'h08D, 9'h032, 4'd1, 1'b0, 6'd7};
        dr[7] = '{6, 0, 9'h08D, 9'h072, 4'd1, 1'b1, 6'd8};
        dr[8] = '{8, 0, 9'h18D, 9'h072, 4'd4, 1'b1, 6'd9};

        rw = '{0, 3, 1, 4, 2};

        fork
            forever begin
                @(negedge clk);
                if (ix0) pop_chk(0, 1'b1);
                if (io0) pop_chk(0, 1'b0);
                if (ix1) pop_chk(1, 1'b1);
                if (io1) pop_chk(1, 1'b0);
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_state", st0, 4'd0);
        chk("rst_x", x0, 9'h0);
        chk("rst_turn", t0, 1'b1);
        chk("rst_start", dsp0, 1'b1);
        chk("rst_flags", {dgx0, dgo0, de0, rsc0, inv0}, 5'b0);
        chk("rst_scores", {sx0, so0, mc0}, 14'h0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(dg[i], $sformatf("diag%0d", i));
        chk("diag_score", sx0, 4'd1);
        chk("diag_dispx", {dgx0, dgo0, de0, dsp0}, 4'b1000);
        click(0, 3, 0, 1'b0);
        chk("over_ignore_x", x0, 9'h111);
        chk("over_ignore_o", o0, 9'h006);
        rclick(0);
        chk("rc_board", {x0, o0}, 18'h0);
        chk("rc_state", st0, 4'd0);
        chk("rc_turn", t0, 1'b1);

        click(0, 4, 0, 1'b0);
        chk("occ_setup", t0, 1'b0);
        @(negedge clk);
        c0 = 9'h010;
        @(negedge clk);
        chk("occ_inv", inv0, 1'b1);
        c0 = '0;
        @(negedge clk);
        chk("occ_inv_off", inv0, 1'b0);
        chk("occ_o", o0, 9'h000);
        chk("occ_turn", t0, 1'b0);
        chk("occ_state", st0, 4'd1);
        click(0, 3, 0, 1'b0);
        chk("occ_o3", o0, 9'h008);

        @(negedge clk);
        rs0 = 1'b1;
        @(negedge clk);
        rs0 = 1'b0;
        chk("rs_board", {x0, o0}, 18'h0);
        chk("rs_state", st0, 4'd0);
        chk("rs_pulse", rsc0, 1'b1);
        chk("rs_score", sx0, 4'd0);
        @(negedge clk);
        chk("rs_pulse_off", rsc0, 1'b0);

        for (int i = 0; i < 9; i++) run_vec(dr[i], $sformatf("draw%0d", i));
        chk("draw_flag", {de0, dgx0, dgo0}, 3'b100);
        chk("draw_scores", {sx0, so0}, 8'h0);
        rclick(0);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 5; i++) click(0, rw[i], (i == 4) ? 1 : 0, 1'b0);
            rclick(0);
        end
        chk("two_wins", sx0, 4'd2);

        click(0, 0, 0, 1'b0);
        @(negedge clk);
        er0 = 1'b1;
        @(negedge clk);
        chk("er_score", sx0, 4'd0);
        chk("er_pulse", rsc0, 1'b1);
        chk("er_board", x0, 9'h001);
        chk("er_state", st0, 4'd1);
        @(negedge clk);
        er0 = 1'b0;
        chk("er_repulse", rsc0, 1'b1);
        @(negedge clk);
        chk("er_pulse_off", rsc0, 1'b0);

        for (int i = 1; i < 5; i++) click(0, rw[i], (i == 4) ? 1 : 0, i == 4);
        chk("erwin_score", sx0, 4'd0);
        chk("erwin_pulse", rsc0, 1'b1);
        chk("erwin_state", st0, 4'd4);
        rclick(0);

        @(negedge clk);
        c0 = 9'h020;
        repeat (10) @(negedge clk);
        c0 = '0;
        repeat (3) @(negedge clk);
        chk("hold_mc", mc0, 6'd1);
        chk("hold_x", x0, 9'h020);
        chk("hold_turn", t0, 1'b0);

        click(1, 6, 0, 1'b0);
        click(1, 0, 0, 1'b0);
        click(1, 7, 0, 1'b0);
        click(1, 1, 0, 1'b0);
        click(1, 8, 0, 1'b0);
        chk("n5_pre_state", st1, 4'd1);
        click(1, 2, 0, 1'b0);
        click(1, 9, 1, 1'b0);
        chk("n5_state", st1, 4'd4);
        chk("n5_x", x1, 25'h3C0);
        chk("n5_score", sx1, 2'd1);
        chk("n5_dispx", dgx1, 1'b1);
        rclick(1);
        chk("alt_turn1", t1, 1'b0);

        for (int g = 2; g <= 4; g++) begin
            click(1, 0, 0, 1'b0);
            chk($sformatf("alt_o_first%0d", g), {x1, o1}, 50'h1);
            click(1, 20, 0, 1'b0);
            click(1, 1, 0, 1'b0);
            click(1, 21, 0, 1'b0);
            click(1, 2, 0, 1'b0);
            click(1, 22, 0, 1'b0);
            click(1, 10, 0, 1'b0);
            click(1, 23, 1, 1'b0);
            chk($sformatf("corner_x%0d", g), x1, 25'hF00000);
            chk($sformatf("corner_st%0d", g), st1, 4'd4);
            chk($sformatf("sat_score%0d", g), sx1, (g > 3) ? 2'd3 : 2'(g));
            rclick(1);
            chk($sformatf("alt_turn%0d", g), t1, 1'b0);
        end

        @(negedge clk);
        c1 = 25'(1) << 12;
        @(posedge clk);
        #1;
        chk("ar_place", st1, 4'd2);
        c1 = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_state", st1, 4'd0);
        chk("ar_turn", t1, 1'b1);
        chk("ar_score", sx1, 2'd0);
        chk("ar_start", dsp1, 1'b1);
        chk("ar_board", {x1, o1, mc1}, 56'h0);
        @(negedge clk);
        rst = 1'b0;

        repeat (2) @(negedge clk);
        chk("pulse_missing", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
